decode_stage: RTL and testbench

Parametrised decode stage for the rv5stage pipeline, sitting between fetch and execute. It buffers fetched (pc, inst) pairs in a small instruction queue and decodes the RV32I instruction at the head. Decoded fields go into a registered output slot under a valid/ready handshake. A load-use scoreboard of configurable depth inserts bubbles, and the stage optionally decodes the M extension.

---
 rtl/decode_stage.sv | 232 +++++++++++++++++++++++
 tb/tb_decode_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I(+M) decode stage: fetch-side instruction queue, combinational head decode,
// load-use scoreboard and a registered valid/ready output slot.
module decode_stage #(
  parameter int QUEUE_DEPTH     = 4,
  parameter int LOAD_USE_CYCLES = 1,
  parameter int EN_M            = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [31:0]                      in_pc,
  input  logic [31:0]                      in_inst,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [31:0]                      out_pc,
  output logic [4:0]                       out_rd,
  output logic [4:0]                       out_rs1,
  output logic [4:0]                       out_rs2,
  output logic [2:0]                       out_funct3,
  output logic [6:0]                       out_funct7,
  output logic [31:0]                      out_imm,
  output logic                             out_rd_valid,
  output logic                             out_rs1_valid,
  output logic                             out_rs2_valid,
  output logic [9:0]                       out_ctrl,
  output logic                             out_system,
  output logic                             out_illegal,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] occupancy
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(QUEUE_DEPTH);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // {mul_div, reg_write, alu_src, lo_imm, pc_rel, branch, uncond, mem_read, mem_write, mem_to_reg}
  localparam logic [9:0] CTRL_OP_IMM = 10'h180;
  localparam logic [9:0] CTRL_OP     = 10'h100;
  localparam logic [9:0] CTRL_MULDIV = 10'h300;
  localparam logic [9:0] CTRL_LOAD   = 10'h185;
  localparam logic [9:0] CTRL_STORE  = 10'h082;
  localparam logic [9:0] CTRL_BRANCH = 10'h030;
  localparam logic [9:0] CTRL_LUI    = 10'h1C0;
  localparam logic [9:0] CTRL_AUIPC  = 10'h1E0;
  localparam logic [9:0] CTRL_JAL    = 10'h1B8;
  localparam logic [9:0] CTRL_JALR   = 10'h198;

  logic [31:0]   q_pc   [QUEUE_DEPTH];
  logic [31:0]   q_inst [QUEUE_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [4:0]    sb [LOAD_USE_CYCLES];

  logic [31:0] head_pc;
  logic [31:0] inst;
  logic        head_valid;
  logic [6:0]  opcode;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [9:0]  raw_ctrl;
  logic [31:0] raw_imm;
  logic        raw_rs1_use, raw_rs2_use, raw_system, illegal;
  logic [9:0]  dec_ctrl;
  logic [31:0] dec_imm;
  logic        dec_rs1_valid, dec_rs2_valid, dec_system;
  logic        hazard, held, issue, enq, load_issue;

  assign head_pc    = q_pc[rd_ptr];
  assign inst       = q_inst[rd_ptr];
  assign head_valid = (count != {CW{1'b0}});
  assign opcode     = inst[6:0];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'h000};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // Per-opcode control, immediate selection and legality of the head instruction
  always_comb begin
    raw_ctrl    = 10'h000;
    raw_imm     = 32'h0000_0000;
    raw_rs1_use = 1'b0;
    raw_rs2_use = 1'b0;
    raw_system  = 1'b0;
    illegal     = 1'b0;
    case (opcode)
      OPC_OP_IMM: begin raw_ctrl = CTRL_OP_IMM; raw_imm = imm_i; raw_rs1_use = 1'b1; end
      OPC_OP: begin
        raw_rs1_use = 1'b1;
        raw_rs2_use = 1'b1;
        if (inst[31:25] == 7'b0000000 || inst[31:25] == 7'b0100000) begin
          raw_ctrl = CTRL_OP;
        end else if (inst[31:25] == 7'b0000001 && EN_M != 0) begin
          raw_ctrl = CTRL_MULDIV;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_LOAD:   begin raw_ctrl = CTRL_LOAD;   raw_imm = imm_i; raw_rs1_use = 1'b1; end
      OPC_STORE: begin
        raw_ctrl = CTRL_STORE; raw_imm = imm_s; raw_rs1_use = 1'b1; raw_rs2_use = 1'b1;
      end
      OPC_BRANCH: begin
        raw_ctrl = CTRL_BRANCH; raw_imm = imm_b; raw_rs1_use = 1'b1; raw_rs2_use = 1'b1;
      end
      OPC_LUI:    begin raw_ctrl = CTRL_LUI;   raw_imm = imm_u; end
      OPC_AUIPC:  begin raw_ctrl = CTRL_AUIPC; raw_imm = imm_u; end
      OPC_JAL:    begin raw_ctrl = CTRL_JAL;   raw_imm = imm_j; end
      OPC_JALR:   begin raw_ctrl = CTRL_JALR;  raw_imm = imm_i; raw_rs1_use = 1'b1; end
      OPC_FENCE:  begin raw_ctrl = 10'h000; end
      OPC_SYSTEM: begin raw_system = 1'b1; end
      default:    begin illegal = 1'b1; end
    endcase
  end

  // Illegal encodings still issue, but with every control and operand flag cleared
  assign dec_ctrl      = illegal ? 10'h000 : raw_ctrl;
  assign dec_imm       = illegal ? 32'h0000_0000 : raw_imm;
  assign dec_rs1_valid = raw_rs1_use & ~illegal;
  assign dec_rs2_valid = raw_rs2_use & ~illegal;
  assign dec_system    = raw_system & ~illegal;

  // Load-use hazard: a used, nonzero source register matches a pending load destination
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < LOAD_USE_CYCLES; i++) begin
      if (sb[i] != 5'd0 && ((dec_rs1_valid && inst[19:15] == sb[i]) ||
                            (dec_rs2_valid && inst[24:20] == sb[i]))) begin
        hazard = 1'b1;
      end else begin
        hazard = hazard;
      end
    end
    hazard = hazard & head_valid;
  end

  assign in_ready   = (count != FULL_COUNT) && !rst;
  assign held       = out_valid && !out_ready;
  assign issue      = head_valid && !hazard && !held && !flush;
  assign enq        = in_valid && in_ready && !flush;
  assign load_issue = issue && dec_ctrl[2] && (inst[11:7] != 5'd0);
  assign occupancy  = count;

  // Queue storage; no reset needed because count gates every read
  always_ff @(posedge clk) begin
    if (enq) begin
      q_pc[wr_ptr]   <= in_pc;
      q_inst[wr_ptr] <= in_inst;
    end
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= {PW{1'b0}};
      rd_ptr <= {PW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (issue) rd_ptr <= rd_ptr + PW'(1);
      case ({enq, issue})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Scoreboard shifts only when the slot moves, so downstream stalls do not consume bubbles
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < LOAD_USE_CYCLES; i++) sb[i] <= 5'd0;
    end else if (!held) begin
      sb[0] <= load_issue ? inst[11:7] : 5'd0;
      for (int i = 1; i < LOAD_USE_CYCLES; i++) sb[i] <= sb[i-1];
    end
  end

  // Registered output slot
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_pc        <= 32'h0000_0000;
      out_rd        <= 5'd0;
      out_rs1       <= 5'd0;
      out_rs2       <= 5'd0;
      out_funct3    <= 3'd0;
      out_funct7    <= 7'd0;
      out_imm       <= 32'h0000_0000;
      out_rd_valid  <= 1'b0;
      out_rs1_valid <= 1'b0;
      out_rs2_valid <= 1'b0;
      out_ctrl      <= 10'h000;
      out_system    <= 1'b0;
      out_illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (issue) begin
      out_valid     <= 1'b1;
      out_pc        <= head_pc;
      out_rd        <= inst[11:7];
      out_rs1       <= inst[19:15];
      out_rs2       <= inst[24:20];
      out_funct3    <= inst[14:12];
      out_funct7    <= inst[31:25];
      out_imm       <= dec_imm;
      out_rd_valid  <= dec_ctrl[8];
      out_rs1_valid <= dec_rs1_valid;
      out_rs2_valid <= dec_rs2_valid;
      out_ctrl      <= dec_ctrl;
      out_system    <= dec_system;
      out_illegal   <= illegal;
    end else if (!held) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: two instances (LOAD_USE_CYCLES=1/EN_M=0 and
// LOAD_USE_CYCLES=3/EN_M=1) share stimulus; a negedge monitor pops expected entries.
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        rdv;
    logic        rs1v;
    logic        rs2v;
    logic [9:0]  ctrl;
    logic        sys;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready;
  logic [31:0] in_pc, in_inst;

  logic a_in_ready, a_out_valid, a_rdv, a_rs1v, a_rs2v, a_sys, a_ill;
  logic [31:0] a_pc, a_imm;
  logic [4:0] a_rd, a_rs1, a_rs2;
  logic [2:0] a_f3, a_occ;
  logic [6:0] a_f7;
  logic [9:0] a_ctrl;
  logic b_in_ready, b_out_valid, b_rdv, b_rs1v, b_rs2v, b_sys, b_ill;
  logic [31:0] b_pc, b_imm;
  logic [4:0] b_rd, b_rs1, b_rs2;
  logic [2:0] b_f3, b_occ;
  logic [6:0] b_f7;
  logic [9:0] b_ctrl;

  exp_t qa[$];
  exp_t qb[$];
  int   ta[$];
  int   tb[$];
  int   cyc = 0;
  int   enq_cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  decode_stage #(.QUEUE_DEPTH(4), .LOAD_USE_CYCLES(1), .EN_M(0)) u_dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_pc), .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2), .out_funct3(a_f3),
    .out_funct7(a_f7), .out_imm(a_imm), .out_rd_valid(a_rdv), .out_rs1_valid(a_rs1v),
    .out_rs2_valid(a_rs2v), .out_ctrl(a_ctrl), .out_system(a_sys), .out_illegal(a_ill),
    .occupancy(a_occ));

  decode_stage #(.QUEUE_DEPTH(4), .LOAD_USE_CYCLES(3), .EN_M(1)) u_dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_pc), .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2), .out_funct3(b_f3),
    .out_funct7(b_f7), .out_imm(b_imm), .out_rd_valid(b_rdv), .out_rs1_valid(b_rs1v),
    .out_rs2_valid(b_rs2v), .out_ctrl(b_ctrl), .out_system(b_sys), .out_illegal(b_ill),
    .occupancy(b_occ));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Register fields come straight from the word; the rest is supplied by hand.
  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] inst,
                              input logic [31:0] imm, input logic [9:0] ctrl,
                              input logic [2:0] v, input logic sys, input logic ill);
    exp_t e;
    e.pc = pc; e.rd = inst[11:7]; e.rs1 = inst[19:15]; e.rs2 = inst[24:20];
    e.f3 = inst[14:12]; e.f7 = inst[31:25]; e.imm = imm;
    e.rdv = v[2]; e.rs1v = v[1]; e.rs2v = v[0]; e.ctrl = ctrl; e.sys = sys; e.ill = ill;
    return e;
  endfunction

  // Monitor: every accepted output is compared in order against the expected queues
  always @(negedge clk) begin
    exp_t act;
    if (!rst && a_out_valid && out_ready) begin
      act = {a_pc, a_rd, a_rs1, a_rs2, a_f3, a_f7, a_imm, a_rdv, a_rs1v, a_rs2v, a_ctrl, a_sys, a_ill};
      if (qa.size() == 0) chk("a_unexpected_output", act, 128'h0 - 128'h1);
      else chk("a_fields", act, qa.pop_front());
      ta.push_back(cyc);
    end
    if (!rst && b_out_valid && out_ready) begin
      act = {b_pc, b_rd, b_rs1, b_rs2, b_f3, b_f7, b_imm, b_rdv, b_rs1v, b_rs2v, b_ctrl, b_sys, b_ill};
      if (qb.size() == 0) chk("b_unexpected_output", act, 128'h0 - 128'h1);
      else chk("b_fields", act, qb.pop_front());
      tb.push_back(cyc);
    end
  end

  task automatic push(input logic [31:0] pc, input logic [31:0] inst,
                      input exp_t ea, input exp_t eb, input bit expect_out);
    int t;
    in_pc = pc; in_inst = inst; in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!(a_in_ready && b_in_ready) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      chk("push_timeout", 1, 0);
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      enq_cyc = cyc;
      if (expect_out) begin
        qa.push_back(ea);
        qb.push_back(eb);
      end
    end
  endtask

  task automatic push2(input logic [31:0] pc, input logic [31:0] inst, input exp_t e);
    push(pc, inst, e, e, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_pc = 32'h0; in_inst = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready_a", a_in_ready, 0);
    chk("rst_in_ready_b", b_in_ready, 0);
    chk("rst_out_valid", {a_out_valid, b_out_valid}, 0);
    chk("rst_occupancy", {a_occ, b_occ}, 0);
    chk("rst_fields", {a_pc, a_ctrl, a_imm, a_ill, b_pc, b_ctrl, b_imm, b_ill}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {a_in_ready, b_in_ready}, 2'b11);
    @(posedge clk); #1;

    // Back-to-back stream: ADDI x1,x0,5 / ADD x2,x1,x1 / SW x2,4(x0)
    ta.delete(); tb.delete();
    push2(32'h100, 32'h00500093, mk(32'h100, 32'h00500093, 32'd5, 10'h180, 3'b110, 0, 0));
    push2(32'h104, 32'h00108133, mk(32'h104, 32'h00108133, 32'd0, 10'h100, 3'b111, 0, 0));
    push2(32'h108, 32'h00202223, mk(32'h108, 32'h00202223, 32'd4, 10'h082, 3'b011, 0, 0));
    idle(6);
    chk("stream_gap1", (ta.size() >= 3) ? ta[1] - ta[0] : -1, 1);
    chk("stream_gap2", (ta.size() >= 3) ? ta[2] - ta[1] : -1, 1);

    // Load-use: LW x5,0(x1) then ADD x6,x5,x5
    ta.delete(); tb.delete();
    push2(32'h200, 32'h0000A283, mk(32'h200, 32'h0000A283, 32'd0, 10'h185, 3'b110, 0, 0));
    push2(32'h204, 32'h00528333, mk(32'h204, 32'h00528333, 32'd0, 10'h100, 3'b111, 0, 0));
    idle(10);
    chk("load_use_gap_luc1", (ta.size() >= 2) ? ta[1] - ta[0] : -1, 2);
    chk("load_use_gap_luc3", (tb.size() >= 2) ? tb[1] - tb[0] : -1, 4);

    // Load to x0 followed by an x0 consumer: no bubble
    ta.delete(); tb.delete();
    push2(32'h300, 32'h0000A003, mk(32'h300, 32'h0000A003, 32'd0, 10'h185, 3'b110, 0, 0));
    push2(32'h304, 32'h00000333, mk(32'h304, 32'h00000333, 32'd0, 10'h100, 3'b111, 0, 0));
    idle(8);
    chk("x0_gap_luc1", (ta.size() >= 2) ? ta[1] - ta[0] : -1, 1);
    chk("x0_gap_luc3", (tb.size() >= 2) ? tb[1] - tb[0] : -1, 1);

    // Decode variety: MUL (EN_M differs), all-ones word, JALR, JAL, LUI, ECALL
    push(32'h400, 32'h022081B3,
         mk(32'h400, 32'h022081B3, 32'd0, 10'h000, 3'b000, 0, 1),
         mk(32'h400, 32'h022081B3, 32'd0, 10'h300, 3'b111, 0, 0), 1'b1);
    push2(32'h404, 32'hFFFFFFFF, mk(32'h404, 32'hFFFFFFFF, 32'd0, 10'h000, 3'b000, 0, 1));
    push2(32'h408, 32'hFFC100E7, mk(32'h408, 32'hFFC100E7, 32'hFFFFFFFC, 10'h198, 3'b110, 0, 0));
    push2(32'h40C, 32'h001000EF, mk(32'h40C, 32'h001000EF, 32'h00000800, 10'h1B8, 3'b100, 0, 0));
    push2(32'h410, 32'h12345237, mk(32'h410, 32'h12345237, 32'h12345000, 10'h1C0, 3'b100, 0, 0));
    push2(32'h414, 32'h00000073, mk(32'h414, 32'h00000073, 32'd0, 10'h000, 3'b000, 1, 0));
    idle(8);

    // Held slot: five ADDI xk,x0,k with out_ready low
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      w = (32'(k) << 20) | (32'(k) << 7) | 32'h13;
      push2(32'h500 + 32'(4 * k), w, mk(32'h500 + 32'(4 * k), w, 32'(k), 10'h180, 3'b110, 0, 0));
    end
    @(negedge clk);
    chk("full_in_ready", {a_in_ready, b_in_ready}, 0);
    chk("full_occupancy", {a_occ, b_occ}, {3'd4, 3'd4});
    chk("held_first", {a_out_valid, a_pc, a_imm}, {1'b1, 32'h504, 32'd1});
    idle(3);
    @(negedge clk);
    chk("held_stable_a", {a_out_valid, a_pc, a_imm, a_rd}, {1'b1, 32'h504, 32'd1, 5'd1});
    chk("held_stable_b", {b_out_valid, b_pc, b_imm, b_rd}, {1'b1, 32'h504, 32'd1, 5'd1});
    @(posedge clk); #1;
    out_ready = 1'b1;
    idle(10);
    chk("drain_a_empty", qa.size(), 0);

    // Flush with three queued entries and a pending load-use bubble
    out_ready = 1'b0;
    push2(32'h600, 32'h00100413, mk(32'h600, 32'h00100413, 32'd1, 10'h180, 3'b110, 0, 0));
    push2(32'h604, 32'h0000A283, mk(32'h604, 32'h0000A283, 32'd0, 10'h185, 3'b110, 0, 0));
    push(32'h608, 32'h00528333, mk(0, 0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0, 0), 1'b0);
    push(32'h60C, 32'h00200493, mk(0, 0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0, 0), 1'b0);
    push(32'h610, 32'h00300513, mk(0, 0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0, 0), 1'b0);
    out_ready = 1'b1;
    idle(1);
    flush = 1'b1;
    @(negedge clk);
    chk("pre_flush_occupancy", {a_occ, b_occ}, {3'd3, 3'd3});
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", {a_out_valid, b_out_valid}, 0);
    chk("flush_occupancy", {a_occ, b_occ}, 0);
    @(posedge clk); #1;
    ta.delete(); tb.delete();
    push2(32'h700, 32'h00528333, mk(32'h700, 32'h00528333, 32'd0, 10'h100, 3'b111, 0, 0));
    idle(6);
    chk("post_flush_latency_a", (ta.size() >= 1) ? ta[0] - enq_cyc : -1, 1);
    chk("post_flush_latency_b", (tb.size() >= 1) ? tb[0] - enq_cyc : -1, 1);

    chk("final_qa_empty", qa.size(), 0);
    chk("final_qb_empty", qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
